// File: rtl/vcache_stat_snapshot.sv
// Load/store hit-miss counters fed by a vcache v/yumi port, with tagged snapshots
// queued in a small record FIFO and streamed out as 6-word records over valid/yumi.
//
// Ports:
//   clk_i, reset_n_i         clock, async active-low reset
//   cache_v_i/cache_yumi_i   vcache output handshake (event when both high)
//   cache_miss_i/ld/st_op_i  qualifiers for the accepted event
//   global_ctr_i             free-running cycle count captured with a snapshot
//   snap_v_i/snap_tag_i      snapshot request and tag; snap_ready_o = FIFO not full
//   drop_count_o             saturating count of snapshots refused while full
//   out_v_o/out_data_o       record word stream; out_last_o marks word 5
//   out_yumi_i               consumer takes the current word
module vcache_stat_snapshot #(
    parameter int data_width_p    = 32,
    parameter int ctr_width_p     = 32,
    parameter int els_p           = 2,
    parameter int clear_on_snap_p = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    cache_v_i,
    input  logic                    cache_yumi_i,
    input  logic                    cache_miss_i,
    input  logic                    cache_ld_op_i,
    input  logic                    cache_st_op_i,
    input  logic [31:0]             global_ctr_i,
    input  logic                    snap_v_i,
    input  logic [data_width_p-1:0] snap_tag_i,
    output logic                    snap_ready_o,
    output logic [15:0]             drop_count_o,
    output logic                    out_v_o,
    output logic [data_width_p-1:0] out_data_o,
    output logic                    out_last_o,
    input  logic                    out_yumi_i
);

    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    localparam logic [ctr_width_p-1:0] ctr_one = ctr_width_p'(1);
    localparam logic [ptr_w-1:0]       ptr_one = ptr_w'(1);
    localparam logic [ptr_w-1:0]       ptr_max = ptr_w'(els_p - 1);
    localparam logic [cnt_w-1:0]       cnt_one = cnt_w'(1);
    localparam logic [cnt_w-1:0]       cnt_max = cnt_w'(els_p);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    typedef struct packed {
        logic [data_width_p-1:0] tag;
        logic [31:0]             gctr;
        logic [ctr_width_p-1:0]  ld;
        logic [ctr_width_p-1:0]  st;
        logic [ctr_width_p-1:0]  ld_miss;
        logic [ctr_width_p-1:0]  st_miss;
    } rec_t;

    function automatic logic [ctr_width_p-1:0] sat_inc(
        input logic [ctr_width_p-1:0] v,
        input logic                   inc
    );
        sat_inc = (inc && !(&v)) ? v + ctr_one : v;
    endfunction

    logic                   acc;
    logic [ctr_width_p-1:0] ld, st, ld_miss, st_miss;
    logic [ctr_width_p-1:0] ld_n, st_n, ld_miss_n, st_miss_n;

    rec_t             mem [els_p];
    rec_t             head;
    logic [ptr_w-1:0] wr_ptr, rd_ptr;
    logic [cnt_w-1:0] count, count_n;
    logic             full, empty, push, pop;

    state_t           state, state_n;
    logic [2:0]       word_idx, word_idx_n;
    logic             last;
    logic [data_width_p-1:0] word;
    logic [15:0]      drops;

    assign acc       = cache_v_i & cache_yumi_i;
    assign ld_n      = sat_inc(ld, acc & cache_ld_op_i);
    assign st_n      = sat_inc(st, acc & cache_st_op_i);
    assign ld_miss_n = sat_inc(ld_miss, acc & cache_ld_op_i & cache_miss_i);
    assign st_miss_n = sat_inc(st_miss, acc & cache_st_op_i & cache_miss_i);

    assign full  = (count == cnt_max);
    assign empty = (count == '0);
    assign push  = snap_v_i & ~full;
    assign last  = (word_idx == 3'd5);
    assign pop   = (state == SEND) & out_yumi_i & last;
    assign head  = mem[rd_ptr];

    always_comb begin
        count_n = count;
        if (push && !pop) begin
            count_n = count + cnt_one;
        end else if (pop && !push) begin
            count_n = count - cnt_one;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ld      <= '0;
            st      <= '0;
            ld_miss <= '0;
            st_miss <= '0;
        end else if (push && (clear_on_snap_p != 0)) begin
            // the same-cycle event lives only in the captured record
            ld      <= '0;
            st      <= '0;
            ld_miss <= '0;
            st_miss <= '0;
        end else begin
            ld      <= ld_n;
            st      <= st_n;
            ld_miss <= ld_miss_n;
            st_miss <= st_miss_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= '{
                tag:     snap_tag_i,
                gctr:    global_ctr_i,
                ld:      ld_n,
                st:      st_n,
                ld_miss: ld_miss_n,
                st_miss: st_miss_n
            };
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drops  <= '0;
        end else begin
            count <= count_n;
            if (push) begin
                wr_ptr <= (wr_ptr == ptr_max) ? '0 : wr_ptr + ptr_one;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == ptr_max) ? '0 : rd_ptr + ptr_one;
            end
            if (snap_v_i && full && !(&drops)) begin
                drops <= drops + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= IDLE;
            word_idx <= '0;
        end else begin
            state    <= state_n;
            word_idx <= word_idx_n;
        end
    end

    always_comb begin
        state_n    = state;
        word_idx_n = word_idx;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_n    = SEND;
                    word_idx_n = '0;
                end
            end
            SEND: begin
                if (out_yumi_i) begin
                    if (last) begin
                        word_idx_n = '0;
                        // a record enqueued this cycle keeps the stream gap-free
                        if (count_n == '0) begin
                            state_n = IDLE;
                        end
                    end else begin
                        word_idx_n = word_idx + 3'd1;
                    end
                end
            end
            default: begin
                state_n    = IDLE;
                word_idx_n = '0;
            end
        endcase
    end

    always_comb begin
        word = '0;
        case (word_idx)
            3'd0:    word = head.tag;
            3'd1:    word = data_width_p'(head.gctr);
            3'd2:    word = data_width_p'(head.ld);
            3'd3:    word = data_width_p'(head.st);
            3'd4:    word = data_width_p'(head.ld_miss);
            3'd5:    word = data_width_p'(head.st_miss);
            default: word = '0;
        endcase
    end

    assign snap_ready_o = ~full;
    assign drop_count_o = drops;
    assign out_v_o      = (state == SEND);
    assign out_data_o   = word;
    assign out_last_o   = out_v_o & last;

    yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) out_yumi_i |-> out_v_o
    ) else $error("out_yumi_i asserted while out_v_o is low");

endmodule

// File: tb/tb_vcache_stat_snapshot.sv
// Bench for vcache_stat_snapshot: two instances (32-bit keep-counters, 4-bit
// clear-on-snapshot) share stimulus and are compared against a queue-based model.
module tb_vcache_stat_snapshot;

    localparam int ELS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cache_v, cache_yumi, miss, ld_op, st_op;
    logic        snap_v, yumi_req;
    logic [31:0] gctr, tag;
    logic [1:0]  rdy, ov, ol, yum;
    logic [31:0] od [2];
    logic [15:0] dc [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign yum = {2{yumi_req}} & ov;

    vcache_stat_snapshot #(
        .data_width_p(32), .ctr_width_p(32), .els_p(ELS), .clear_on_snap_p(0)
    ) dut_a (
        .clk_i(clk), .reset_n_i(rst_n),
        .cache_v_i(cache_v), .cache_yumi_i(cache_yumi), .cache_miss_i(miss),
        .cache_ld_op_i(ld_op), .cache_st_op_i(st_op), .global_ctr_i(gctr),
        .snap_v_i(snap_v), .snap_tag_i(tag), .snap_ready_o(rdy[0]),
        .drop_count_o(dc[0]), .out_v_o(ov[0]), .out_data_o(od[0]),
        .out_last_o(ol[0]), .out_yumi_i(yum[0])
    );

    vcache_stat_snapshot #(
        .data_width_p(32), .ctr_width_p(4), .els_p(ELS), .clear_on_snap_p(1)
    ) dut_b (
        .clk_i(clk), .reset_n_i(rst_n),
        .cache_v_i(cache_v), .cache_yumi_i(cache_yumi), .cache_miss_i(miss),
        .cache_ld_op_i(ld_op), .cache_st_op_i(st_op), .global_ctr_i(gctr),
        .snap_v_i(snap_v), .snap_tag_i(tag), .snap_ready_o(rdy[1]),
        .drop_count_o(dc[1]), .out_v_o(ov[1]), .out_data_o(od[1]),
        .out_last_o(ol[1]), .out_yumi_i(yum[1])
    );

    // reference model: counters as integers, pending records as a word queue
    int        cw  [2] = '{32, 4};
    bit        clr [2] = '{1'b0, 1'b1};
    longint    cnt [2][4];
    int        drop [2];
    bit [31:0] wq [2][$];
    int        widx [2];
    bit        act [2];
    bit [32:0] cap [2][$];

    typedef struct {
        int        n_lh, n_lm, n_sh, n_sm, n_nop;
        bit [31:0] tag, gctr;
        int        a_ld, a_st, a_lm, a_sm;
        int        b_ld, b_st, b_lm, b_sm;
    } vec_t;

    vec_t vecs [5];

    function automatic void chk(string nm, int inst, longint got, longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", nm, inst, got, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) cnt[i][k] = 0;
            drop[i] = 0;
            wq[i].delete();
            cap[i].delete();
            widx[i] = 0;
            act[i]  = 1'b0;
        end
    endfunction

    function automatic void model_step();
        bit     acc, ready, popped, take;
        int     pre;
        longint mx;
        longint inc [4];
        longint nc [4];
        acc    = cache_v & cache_yumi;
        inc[0] = longint'(acc & ld_op);
        inc[1] = longint'(acc & st_op);
        inc[2] = longint'(acc & ld_op & miss);
        inc[3] = longint'(acc & st_op & miss);
        for (int i = 0; i < 2; i++) begin
            pre    = wq[i].size() / 6;
            ready  = pre < ELS;
            take   = snap_v && ready;
            mx     = (longint'(1) << cw[i]) - 1;
            popped = 1'b0;
            for (int k = 0; k < 4; k++)
                nc[k] = (cnt[i][k] + inc[k] > mx) ? mx : cnt[i][k] + inc[k];
            if (act[i] && yumi_req) begin
                if (widx[i] == 5) begin
                    repeat (6) void'(wq[i].pop_front());
                    widx[i] = 0;
                    popped  = 1'b1;
                end else begin
                    widx[i]++;
                end
            end
            if (take) begin
                wq[i].push_back(tag);
                wq[i].push_back(gctr);
                for (int k = 0; k < 4; k++) wq[i].push_back(32'(nc[k]));
            end else if (snap_v && drop[i] < 65535) begin
                drop[i]++;
            end
            for (int k = 0; k < 4; k++)
                cnt[i][k] = (take && clr[i]) ? 0 : nc[k];
            if (!act[i]) act[i] = pre > 0;
            else if (popped) act[i] = wq[i].size() > 0;
        end
    endfunction

    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("snap_ready", i, rdy[i], wq[i].size() < 6 * ELS);
            chk("out_v", i, ov[i], act[i]);
            chk("drop_count", i, dc[i], drop[i]);
            if (act[i] && wq[i].size() > widx[i]) begin
                chk("out_data", i, od[i], wq[i][widx[i]]);
                chk("out_last", i, ol[i], widx[i] == 5);
            end else begin
                chk("out_last_idle", i, ol[i], 0);
            end
            if (ov[i] && yumi_req) cap[i].push_back({ol[i], od[i]});
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cache_v = 0; cache_yumi = 0; miss = 0; ld_op = 0; st_op = 0;
        snap_v = 0; tag = 0; gctr = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        yumi_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic ev(input bit v, input bit y, input bit l, input bit s, input bit m);
        cache_v = v; cache_yumi = y; ld_op = l; st_op = s; miss = m;
        cycle();
        cache_v = 0; cache_yumi = 0; ld_op = 0; st_op = 0; miss = 0;
    endtask

    task automatic snap(input bit [31:0] t, input bit [31:0] g);
        tag = t; gctr = g; snap_v = 1;
        cycle();
        snap_v = 0;
    endtask

    task automatic drain(input int n);
        yumi_req = 1;
        for (int c = 0; c < 6 * n + 20; c++) begin
            if (cap[0].size() >= n && cap[1].size() >= n) break;
            cycle();
        end
        yumi_req = 0;
        chk("drain_count", 0, cap[0].size(), n);
        chk("drain_count", 1, cap[1].size(), n);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3, 2, 3, 1, 4, 32'hA5, 32'd100, 5, 4, 2, 1, 5, 4, 2, 1};
        vecs[1] = '{20, 0, 0, 0, 2, 32'h1234, 32'd7, 20, 0, 0, 0, 15, 0, 0, 0};
        vecs[2] = '{0, 17, 0, 16, 0, 32'hFFFF_FFFF, 32'hDEAD_BEEF,
                    17, 16, 17, 16, 15, 15, 15, 15};
        vecs[3] = '{0, 0, 0, 0, 3, 32'h0, 32'd1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{1, 1, 1, 1, 1, 32'h5A5A_0000, 32'h1234_5678,
                    2, 2, 1, 1, 2, 2, 1, 1};

        do_reset();
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", i, rdy[i], 1);
            chk("rst_out_v", i, ov[i], 0);
            chk("rst_last", i, ol[i], 0);
            chk("rst_drop", i, dc[i], 0);
        end

        // table-driven single-record vectors
        foreach (vecs[n]) begin
            vec_t   v;
            longint ea [6];
            longint eb [6];
            v = vecs[n];
            do_reset();
            repeat (v.n_lh) ev(1, 1, 1, 0, 0);
            repeat (v.n_lm) ev(1, 1, 1, 0, 1);
            repeat (v.n_sh) ev(1, 1, 0, 1, 0);
            repeat (v.n_sm) ev(1, 1, 0, 1, 1);
            for (int j = 0; j < v.n_nop; j++) begin
                if (j % 2 == 1) ev(1, 0, 1, 0, 1);
                else ev(0, 1, 0, 1, 1);
            end
            snap(v.tag, v.gctr);
            drain(6);
            ea = '{v.tag, v.gctr, v.a_ld, v.a_st, v.a_lm, v.a_sm};
            eb = '{v.tag, v.gctr, v.b_ld, v.b_st, v.b_lm, v.b_sm};
            for (int k = 0; k < 6 && k < cap[0].size(); k++) begin
                chk("vec_word_a", n * 10 + k, cap[0][k][31:0], ea[k]);
                chk("vec_last_a", n * 10 + k, cap[0][k][32], k == 5);
            end
            for (int k = 0; k < 6 && k < cap[1].size(); k++) begin
                chk("vec_word_b", n * 10 + k, cap[1][k][31:0], eb[k]);
                chk("vec_last_b", n * 10 + k, cap[1][k][32], k == 5);
            end
        end

        // snapshot in the same cycle as an accepted load miss
        do_reset();
        ev(1, 1, 1, 0, 0);
        ev(1, 1, 1, 0, 0);
        cache_v = 1; cache_yumi = 1; ld_op = 1; miss = 1;
        snap(32'd1, 32'd50);
        cache_v = 0; cache_yumi = 0; ld_op = 0; miss = 0;
        ev(0, 0, 0, 0, 0);
        snap(32'd2, 32'd60);
        drain(12);
        if (cap[0].size() == 12 && cap[1].size() == 12) begin
            chk("same_cyc_ld", 1, cap[1][2][31:0], 3);
            chk("same_cyc_lm", 1, cap[1][4][31:0], 1);
            chk("after_clr_ld", 1, cap[1][8][31:0], 0);
            chk("after_clr_lm", 1, cap[1][10][31:0], 0);
            chk("keep_ld", 0, cap[0][8][31:0], 3);
            chk("keep_lm", 0, cap[0][10][31:0], 1);
        end

        // full FIFO drops the third request
        do_reset();
        snap(32'd10, 32'd1);
        for (int i = 0; i < 2; i++) chk("ready_after_1", i, rdy[i], 1);
        snap(32'd11, 32'd2);
        for (int i = 0; i < 2; i++) chk("ready_after_2", i, rdy[i], 0);
        snap(32'd12, 32'd3);
        for (int i = 0; i < 2; i++) chk("drop_after_3", i, dc[i], 1);

        // two queued records stream without a gap
        begin
            int run;
            run = 0;
            cap[0].delete();
            cap[1].delete();
            yumi_req = 1;
            for (int c = 0; c < 40; c++) begin
                if (ov[0]) run++;
                else if (run > 0) break;
                cycle();
            end
            yumi_req = 0;
            chk("b2b_run", 0, run, 12);
            if (cap[0].size() == 12) begin
                chk("b2b_tag0", 0, cap[0][0][31:0], 10);
                chk("b2b_tag1", 0, cap[0][6][31:0], 11);
                chk("b2b_last", 0, cap[0][11][32], 1);
            end
        end

        // async reset in mid-record
        do_reset();
        repeat (3) ev(1, 1, 1, 1, 1);
        snap(32'd77, 32'd5);
        yumi_req = 1;
        for (int c = 0; c < 20 && cap[0].size() < 3; c++) cycle();
        chk("mid_words", 0, cap[0].size(), 3);
        #2 rst_n = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_out_v", i, ov[i], 0);
            chk("async_ready", i, rdy[i], 1);
        end
        yumi_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        model_reset();
        ev(0, 0, 0, 0, 0);
        snap(32'd88, 32'd9);
        drain(6);
        for (int i = 0; i < 2; i++) begin
            if (cap[i].size() == 6) begin
                chk("post_rst_tag", i, cap[i][0][31:0], 88);
                for (int k = 2; k < 6; k++)
                    chk("post_rst_ctr", i * 10 + k, cap[i][k][31:0], 0);
            end
        end

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cache_v    = 1'($urandom_range(0, 1));
            cache_yumi = 1'($urandom_range(0, 1));
            ld_op      = 1'($urandom_range(0, 1));
            st_op      = 1'($urandom_range(0, 1));
            miss       = 1'($urandom_range(0, 1));
            snap_v     = ($urandom_range(0, 7) == 0);
            yumi_req   = ($urandom_range(0, 3) != 0);
            tag        = $urandom;
            gctr       = 32'(c);
            cycle();
        end
        idle_inputs();
        yumi_req = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
